f18a_gpu_mux: RTL and testbench

- Lets NUM_GPUS interchangeable co-processors share the single F18A GPU port.
- Sits between the F18A core's GPU signals and the GPU instances.
- Routes trigger/load-PC to the selected GPU and muxes its VRAM, palette, register and status outputs back to the core.
- Switches between GPUs at runtime with a pause/acknowledge drain, a timeout, and triggers deferred across the switch.
- Broadcast core signals (vdin, pdin, rdin, scanline, blank, bmlba, bml_w, pgba) fan out externally and are not handled here.

---
 rtl/f18a_gpu_mux.sv | 174 +++++++++++++++++
 tb/tb_f18a_gpu_mux.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/f18a_gpu_mux.sv
// f18a_gpu_mux: shares the single F18A GPU port among NUM_GPUS co-processors.
// Strobes go to the selected slot. The selected slot's VRAM, palette, register and
// status outputs are muxed back to the core.
// A runtime switch pauses the old slot and waits for it to drain. A timeout bounds
// that wait. Strobes that arrive during the switch are replayed on the new slot.
//
// Ports:
//   clk_logic_i, reset_i          clock, synchronous active-high reset
//   sel_req_i / sel_id_i          switch request and target slot
//   sel_o / sel_busy_o / sel_err_o  current slot, switch in progress, sticky error
//   trigger_i / load_pc_i / pause_i  core strobes and pause request
//   pause_ack_o / running_o       selected slot's ack and running flag
//   vwe_o..gstatus_o              muxed write port and status from the selected slot
//   gpu_trigger_o / gpu_load_pc_o / gpu_pause_o  per-slot controls
//   gpu_*_i                       per-slot outputs, packed with slot k at [k*W +: W]
module f18a_gpu_mux #(
  parameter int unsigned NUM_GPUS      = 2,
  parameter int unsigned RESET_SEL     = 0,
  parameter int unsigned VADDR_W       = 14,
  parameter int unsigned PADDR_W       = 6,
  parameter int unsigned PDATA_W       = 12,
  parameter int unsigned RADDR_W       = 6,
  parameter int unsigned GSTAT_W       = 7,
  parameter int unsigned PAUSE_TIMEOUT = 1023,
  localparam int unsigned SEL_W        = (NUM_GPUS > 1) ? $clog2(NUM_GPUS) : 1
) (
  input  logic                          clk_logic_i,
  input  logic                          reset_i,
  input  logic                          sel_req_i,
  input  logic [SEL_W-1:0]              sel_id_i,
  output logic [SEL_W-1:0]              sel_o,
  output logic                          sel_busy_o,
  output logic                          sel_err_o,
  input  logic                          trigger_i,
  input  logic                          load_pc_i,
  input  logic                          pause_i,
  output logic                          pause_ack_o,
  output logic                          running_o,
  output logic                          vwe_o,
  output logic [VADDR_W-1:0]            vaddr_o,
  output logic [7:0]                    vdout_o,
  output logic                          pwe_o,
  output logic [PADDR_W-1:0]            paddr_o,
  output logic [PDATA_W-1:0]            pdout_o,
  output logic                          rwe_o,
  output logic [RADDR_W-1:0]            raddr_o,
  output logic [GSTAT_W-1:0]            gstatus_o,
  output logic [NUM_GPUS-1:0]           gpu_trigger_o,
  output logic [NUM_GPUS-1:0]           gpu_load_pc_o,
  output logic [NUM_GPUS-1:0]           gpu_pause_o,
  input  logic [NUM_GPUS-1:0]           gpu_running_i,
  input  logic [NUM_GPUS-1:0]           gpu_pause_ack_i,
  input  logic [NUM_GPUS-1:0]           gpu_vwe_i,
  input  logic [NUM_GPUS-1:0]           gpu_pwe_i,
  input  logic [NUM_GPUS-1:0]           gpu_rwe_i,
  input  logic [NUM_GPUS*VADDR_W-1:0]   gpu_vaddr_i,
  input  logic [NUM_GPUS*8-1:0]         gpu_vdout_i,
  input  logic [NUM_GPUS*PADDR_W-1:0]   gpu_paddr_i,
  input  logic [NUM_GPUS*PDATA_W-1:0]   gpu_pdout_i,
  input  logic [NUM_GPUS*RADDR_W-1:0]   gpu_raddr_i,
  input  logic [NUM_GPUS*GSTAT_W-1:0]   gpu_gstatus_i
);

  // The drain counter runs 0..PAUSE_TIMEOUT-1, so the wait lasts exactly PAUSE_TIMEOUT cycles.
  localparam int unsigned CNT_W = (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(PAUSE_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StDrain, StSettle} state_e;

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q, tgt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q, pend_trig_q, pend_ld_q;
  logic [NUM_GPUS-1:0] trig_q, ldpc_q;

  logic [NUM_GPUS-1:0] sel_oh;
  logic                id_ok;
  int unsigned         sel_idx;

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  assign id_ok   = (32'(sel_id_i) < NUM_GPUS);
  assign sel_idx = 32'(sel_q);

  always_ff @(posedge clk_logic_i) begin
    if (reset_i) begin
      state_q     <= StRun;
      sel_q       <= SEL_W'(RESET_SEL);
      tgt_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pend_trig_q <= 1'b0;
      pend_ld_q   <= 1'b0;
      trig_q      <= '0;
      ldpc_q      <= '0;
    end else begin
      trig_q <= '0;
      ldpc_q <= '0;
      unique case (state_q)
        StRun: begin
          trig_q <= trigger_i ? sel_oh : '0;
          ldpc_q <= load_pc_i ? sel_oh : '0;
          if (sel_req_i) begin
            if (!id_ok) begin
              err_q <= 1'b1;
            end else if (sel_id_i != sel_q) begin
              tgt_q   <= sel_id_i;
              err_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // The old slot gets no new strobes; they are held for the new slot.
          pend_trig_q <= pend_trig_q | trigger_i;
          pend_ld_q   <= pend_ld_q | load_pc_i;
          if (gpu_pause_ack_i[sel_q] || !gpu_running_i[sel_q]) begin
            sel_q   <= tgt_q;
            state_q <= StSettle;
          end else if (cnt_q == CntLast) begin
            err_q   <= 1'b1;
            sel_q   <= tgt_q;
            state_q <= StSettle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSettle: begin
          // sel_q already names the new slot; replay merged strobes on it.
          trig_q      <= (pend_trig_q | trigger_i) ? sel_oh : '0;
          ldpc_q      <= (pend_ld_q | load_pc_i) ? sel_oh : '0;
          pend_trig_q <= 1'b0;
          pend_ld_q   <= 1'b0;
          state_q     <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign sel_o         = sel_q;
  assign sel_busy_o    = (state_q != StRun);
  assign sel_err_o     = err_q;
  assign gpu_trigger_o = trig_q;
  assign gpu_load_pc_o = ldpc_q;
  assign running_o     = gpu_running_i[sel_q];

  always_comb begin
    gpu_pause_o = '0;
    pause_ack_o = gpu_pause_ack_i[sel_q];
    unique case (state_q)
      StRun:    gpu_pause_o = pause_i ? sel_oh : '0;
      StDrain:  gpu_pause_o = sel_oh;
      StSettle: pause_ack_o = pause_i;
      default:  gpu_pause_o = '0;
    endcase
  end

  // Writes are gated for the one cycle in which the new slot is taking over.
  assign vwe_o     = gpu_vwe_i[sel_q] & (state_q != StSettle);
  assign pwe_o     = gpu_pwe_i[sel_q] & (state_q != StSettle);
  assign rwe_o     = gpu_rwe_i[sel_q] & (state_q != StSettle);
  assign vaddr_o   = gpu_vaddr_i[sel_idx*VADDR_W +: VADDR_W];
  assign vdout_o   = gpu_vdout_i[sel_idx*8 +: 8];
  assign paddr_o   = gpu_paddr_i[sel_idx*PADDR_W +: PADDR_W];
  assign pdout_o   = gpu_pdout_i[sel_idx*PDATA_W +: PDATA_W];
  assign raddr_o   = gpu_raddr_i[sel_idx*RADDR_W +: RADDR_W];
  assign gstatus_o = gpu_gstatus_i[sel_idx*GSTAT_W +: GSTAT_W];

endmodule

// File: tb/tb_f18a_gpu_mux.sv
// Directed bench for f18a_gpu_mux.
// It uses five slots so that slot ids 5 and 7 fit in sel_id_i and can be rejected as out of range.
module tb_f18a_gpu_mux;
  localparam int unsigned NG = 5;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1, sel_req_i = 1'b0, trigger_i = 1'b0, load_pc_i = 1'b0;
  logic          pause_i = 1'b0;
  logic [SW-1:0] sel_id_i = '0;
  logic [SW-1:0] sel_o;
  logic          sel_busy_o, sel_err_o, pause_ack_o, running_o, vwe_o, pwe_o, rwe_o;
  logic [13:0]   vaddr_o;
  logic [7:0]    vdout_o;
  logic [5:0]    paddr_o, raddr_o;
  logic [11:0]   pdout_o;
  logic [6:0]    gstatus_o;
  logic [NG-1:0] gpu_trigger_o, gpu_load_pc_o, gpu_pause_o;
  logic [NG-1:0] gpu_running_i = '1, gpu_pause_ack_i = '0;
  logic [NG-1:0] gpu_vwe_i = 5'b00010, gpu_pwe_i = '0, gpu_rwe_i = '0;
  logic [NG*14-1:0] gpu_vaddr_i;
  logic [NG*8-1:0]  gpu_vdout_i;
  logic [NG*6-1:0]  gpu_paddr_i, gpu_raddr_i;
  logic [NG*12-1:0] gpu_pdout_i;
  logic [NG*7-1:0]  gpu_gstatus_i;

  int n_cmp = 0;
  int n_bad = 0;

  f18a_gpu_mux #(
    .NUM_GPUS(NG), .RESET_SEL(1), .VADDR_W(14), .PADDR_W(6), .PDATA_W(12),
    .RADDR_W(6), .GSTAT_W(7), .PAUSE_TIMEOUT(16)
  ) dut (
    .clk_logic_i(clk), .reset_i(reset_i), .sel_req_i(sel_req_i), .sel_id_i(sel_id_i),
    .sel_o(sel_o), .sel_busy_o(sel_busy_o), .sel_err_o(sel_err_o),
    .trigger_i(trigger_i), .load_pc_i(load_pc_i), .pause_i(pause_i),
    .pause_ack_o(pause_ack_o), .running_o(running_o),
    .vwe_o(vwe_o), .vaddr_o(vaddr_o), .vdout_o(vdout_o),
    .pwe_o(pwe_o), .paddr_o(paddr_o), .pdout_o(pdout_o),
    .rwe_o(rwe_o), .raddr_o(raddr_o), .gstatus_o(gstatus_o),
    .gpu_trigger_o(gpu_trigger_o), .gpu_load_pc_o(gpu_load_pc_o), .gpu_pause_o(gpu_pause_o),
    .gpu_running_i(gpu_running_i), .gpu_pause_ack_i(gpu_pause_ack_i),
    .gpu_vwe_i(gpu_vwe_i), .gpu_pwe_i(gpu_pwe_i), .gpu_rwe_i(gpu_rwe_i),
    .gpu_vaddr_i(gpu_vaddr_i), .gpu_vdout_i(gpu_vdout_i), .gpu_paddr_i(gpu_paddr_i),
    .gpu_pdout_i(gpu_pdout_i), .gpu_raddr_i(gpu_raddr_i), .gpu_gstatus_i(gpu_gstatus_i)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    n_cmp++; if (sel_o !== 3'd1) begin n_bad++; $display("FAIL reset_sel got %0d want 1", sel_o); end
    n_cmp++; if ({gpu_trigger_o, gpu_load_pc_o, gpu_pause_o} !== 15'd0) begin
      n_bad++; $display("FAIL reset_gpu_outs got %h want 0", {gpu_trigger_o, gpu_load_pc_o, gpu_pause_o});
    end
    n_cmp++; if ({sel_busy_o, sel_err_o} !== 2'b00) begin
      n_bad++; $display("FAIL reset_busy_err got %b want 00", {sel_busy_o, sel_err_o});
    end
    n_cmp++; if ({vwe_o, vaddr_o} !== {1'b1, 14'h1234}) begin
      n_bad++; $display("FAIL reset_vram got %b/%h want 1/1234", vwe_o, vaddr_o);
    end
    n_cmp++; if ({gstatus_o, vdout_o, pdout_o} !== {7'h11, 8'hA1, 12'h301}) begin
      n_bad++; $display("FAIL reset_mux got %h/%h/%h want 11/a1/301", gstatus_o, vdout_o, pdout_o);
    end
  endtask

  task automatic test_run_routing;
    pause_i = 1'b1;
    gpu_pause_ack_i = 5'b00010;
    trigger_i = 1'b1;
    #1;
    n_cmp++; if ({gpu_pause_o, pause_ack_o} !== {5'b00010, 1'b1}) begin
      n_bad++; $display("FAIL run_pause got %b/%b want 00010/1", gpu_pause_o, pause_ack_o);
    end
    n_cmp++; if (gpu_trigger_o !== 5'b0) begin
      n_bad++; $display("FAIL run_trig_latency got %b want 00000", gpu_trigger_o);
    end
    tick();
    trigger_i = 1'b0;
    pause_i = 1'b0;
    gpu_pause_ack_i = '0;
    #1;
    n_cmp++; if (gpu_trigger_o !== 5'b00010) begin
      n_bad++; $display("FAIL run_trig got %b want 00010", gpu_trigger_o);
    end
    tick();
    n_cmp++; if (gpu_trigger_o !== 5'b0) begin
      n_bad++; $display("FAIL run_trig_clear got %b want 00000", gpu_trigger_o);
    end
  endtask

  // Switch 1 -> 0, old slot acks at once: one DRAIN cycle, then SETTLE gates writes.
  task automatic test_switch_settle;
    gpu_vwe_i = 5'b00011;
    sel_req_i = 1'b1; sel_id_i = 3'd0;
    tick();
    sel_req_i = 1'b0;
    gpu_pause_ack_i = 5'b00010;
    #1;
    n_cmp++; if ({sel_busy_o, gpu_pause_o, sel_o} !== {1'b1, 5'b00010, 3'd1}) begin
      n_bad++; $display("FAIL drain1 got %b/%b/%0d want 1/00010/1", sel_busy_o, gpu_pause_o, sel_o);
    end
    tick();
    gpu_pause_ack_i = '0;
    pause_i = 1'b1;
    #1;
    n_cmp++; if ({sel_busy_o, sel_o, vwe_o, gpu_pause_o, pause_ack_o, gstatus_o} !==
                 {1'b1, 3'd0, 1'b0, 5'b0, 1'b1, 7'h10}) begin
      n_bad++; $display("FAIL settle got busy=%b sel=%0d vwe=%b pause=%b ack=%b gst=%h want 1/0/0/00000/1/10",
                        sel_busy_o, sel_o, vwe_o, gpu_pause_o, pause_ack_o, gstatus_o);
    end
    tick();
    pause_i = 1'b0;
    #1;
    n_cmp++; if ({sel_busy_o, vwe_o, vaddr_o} !== {1'b0, 1'b1, 14'h1000}) begin
      n_bad++; $display("FAIL post_settle got %b/%b/%h want 0/1/1000", sel_busy_o, vwe_o, vaddr_o);
    end
  endtask

  // Switch 0 -> 2: slot 0 acks on the sixth DRAIN cycle; two triggers during DRAIN merge.
  task automatic test_drain_ack;
    int p0 = 0, bz = 0, t2 = 0, t0 = 0;
    logic [NG-1:0] first_run_trig = '1;
    logic seen_run = 1'b0;
    sel_req_i = 1'b1; sel_id_i = 3'd2;
    tick();
    sel_req_i = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      trigger_i = (i == 2 || i == 4);
      gpu_pause_ack_i = (i == 6) ? 5'b00001 : 5'b00000;
      #1;
      p0 += int'(gpu_pause_o[0]);
      bz += int'(sel_busy_o);
      t2 += int'(gpu_trigger_o[2]);
      t0 += int'(gpu_trigger_o[0]);
      if (!sel_busy_o && !seen_run) begin seen_run = 1'b1; first_run_trig = gpu_trigger_o; end
      tick();
    end
    trigger_i = 1'b0;
    gpu_pause_ack_i = '0;
    n_cmp++; if (p0 !== 6) begin n_bad++; $display("FAIL drain_pause_cycles got %0d want 6", p0); end
    n_cmp++; if (bz !== 7) begin n_bad++; $display("FAIL drain_busy_cycles got %0d want 7", bz); end
    n_cmp++; if (first_run_trig !== 5'b00100) begin
      n_bad++; $display("FAIL deferred_trig got %b want 00100", first_run_trig);
    end
    n_cmp++; if ({t2, t0} !== {32'd1, 32'd0}) begin
      n_bad++; $display("FAIL trig_counts got slot2=%0d slot0=%0d want 1/0", t2, t0);
    end
    n_cmp++; if ({sel_o, sel_err_o} !== {3'd2, 1'b0}) begin
      n_bad++; $display("FAIL drain_end got sel=%0d err=%b want 2/0", sel_o, sel_err_o);
    end
  endtask

  // Switch 2 -> 3, slot 2 never acks: forced switch after 16 DRAIN cycles, error set.
  task automatic test_timeout;
    int p2 = 0, bz = 0, l3 = 0;
    logic [NG-1:0] first_run_ld = '1;
    logic seen_run = 1'b0;
    sel_req_i = 1'b1; sel_id_i = 3'd3;
    tick();
    sel_req_i = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      load_pc_i = (i == 3 || i == 17);
      #1;
      p2 += int'(gpu_pause_o[2]);
      bz += int'(sel_busy_o);
      l3 += int'(gpu_load_pc_o[3]);
      if (!sel_busy_o && !seen_run) begin seen_run = 1'b1; first_run_ld = gpu_load_pc_o; end
      tick();
    end
    load_pc_i = 1'b0;
    n_cmp++; if (p2 !== 16) begin n_bad++; $display("FAIL timeout_pause got %0d want 16", p2); end
    n_cmp++; if (bz !== 17) begin n_bad++; $display("FAIL timeout_busy got %0d want 17", bz); end
    n_cmp++; if ({first_run_ld, l3} !== {5'b01000, 32'd1}) begin
      n_bad++; $display("FAIL deferred_ldpc got %b/%0d want 01000/1", first_run_ld, l3);
    end
    n_cmp++; if ({sel_o, sel_err_o} !== {3'd3, 1'b1}) begin
      n_bad++; $display("FAIL timeout_end got sel=%0d err=%b want 3/1", sel_o, sel_err_o);
    end
    // Next accepted request clears the error; slot 3 idle means no wait.
    gpu_running_i = 5'b10111;
    sel_req_i = 1'b1; sel_id_i = 3'd0;
    tick();
    sel_req_i = 1'b0;
    #1;
    n_cmp++; if ({sel_busy_o, sel_err_o} !== 2'b10) begin
      n_bad++; $display("FAIL err_clear got %b want 10", {sel_busy_o, sel_err_o});
    end
    tick();
    tick();
    gpu_running_i = '1;
    n_cmp++; if ({sel_o, sel_busy_o} !== {3'd0, 1'b0}) begin
      n_bad++; $display("FAIL idle_switch got sel=%0d busy=%b want 0/0", sel_o, sel_busy_o);
    end
  endtask

  task automatic test_bad_and_same_id;
    sel_req_i = 1'b1; sel_id_i = 3'd5;
    tick();
    sel_req_i = 1'b0;
    #1;
    n_cmp++; if ({sel_o, sel_busy_o, sel_err_o} !== {3'd0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL bad_id got sel=%0d busy=%b err=%b want 0/0/1", sel_o, sel_busy_o, sel_err_o);
    end
    sel_req_i = 1'b1; sel_id_i = 3'd0;
    tick();
    sel_req_i = 1'b0;
    tick();
    n_cmp++; if ({sel_o, sel_busy_o, sel_err_o, gpu_pause_o} !== {3'd0, 1'b0, 1'b1, 5'b0}) begin
      n_bad++; $display("FAIL same_id got sel=%0d busy=%b err=%b pause=%b want 0/0/1/00000",
                        sel_o, sel_busy_o, sel_err_o, gpu_pause_o);
    end
  endtask

  task automatic test_reset_mid_switch;
    int tp = 0;
    sel_req_i = 1'b1; sel_id_i = 3'd4;
    tick();
    sel_req_i = 1'b0;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    #1;
    n_cmp++; if ({sel_busy_o, gpu_pause_o} !== {1'b1, 5'b00001}) begin
      n_bad++; $display("FAIL pre_reset got %b/%b want 1/00001", sel_busy_o, gpu_pause_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    n_cmp++; if ({sel_o, sel_busy_o, sel_err_o, gpu_pause_o} !== {3'd1, 1'b0, 1'b0, 5'b0}) begin
      n_bad++; $display("FAIL mid_reset got sel=%0d busy=%b err=%b pause=%b want 1/0/0/00000",
                        sel_o, sel_busy_o, sel_err_o, gpu_pause_o);
    end
    for (int i = 0; i < 5; i++) begin
      tp += int'(|gpu_trigger_o);
      tick();
    end
    n_cmp++; if (tp !== 0) begin n_bad++; $display("FAIL dropped_trig got %0d pulses want 0", tp); end
  endtask

  initial begin
    for (int k = 0; k < int'(NG); k++) begin
      gpu_vaddr_i[k*14 +: 14]  = 14'h1000 + 14'(k * 14'h234);
      gpu_vdout_i[k*8 +: 8]    = 8'hA0 + 8'(k);
      gpu_paddr_i[k*6 +: 6]    = 6'h20 + 6'(k);
      gpu_pdout_i[k*12 +: 12]  = 12'h300 + 12'(k);
      gpu_raddr_i[k*6 +: 6]    = 6'h10 + 6'(k);
      gpu_gstatus_i[k*7 +: 7]  = 7'h10 + 7'(k);
    end
    test_reset();
    test_run_routing();
    test_switch_settle();
    test_drain_ack();
    test_timeout();
    test_bad_and_same_id();
    test_reset_mid_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
